// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes and FSM states.
package mem_pkg;

    // Access size field carried with each memory instruction (2'b11 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // INIT runs the post-reset clear walk, RUN serves pipeline requests
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 data array with per-byte write enables and asynchronous read.
// Each byte lane is its own array so every lane has exactly one writer.
module dmem_bank #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Byte-lane write, only when the lane's enable is set
            always_ff @(posedge clk) begin
                if (we_i && be_i[gi]) begin
                    lane_mem[addr_i] <= wdata_i[8*gi +: 8];
                end
            end

            assign rdata_o[8*gi +: 8] = lane_mem[addr_i];
        end
    endgenerate

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM stage: byte-addressed little-endian data memory, load extension,
// misalignment detection, post-reset clear walk and the MEM/WB register.
// Build option: define MEM_PRELOAD_EN to fill word i with i during the walk
// instead of clearing it to zero.
module mem_stage_dmem
    import mem_pkg::*;
#(
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              clrn,
    output logic              ready,
    input  logic              en,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       datain,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [4:0]        mrn,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [4:0]        wrn,
    output logic [31:0]       wmo,
    output logic [31:0]       walu,
    output logic              misalign
);

    localparam int              WI_W      = ADDR_W - 2;
    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [WI_W-1:0] cnt_q, cnt_d;

    logic [WI_W-1:0] wi;
    logic [1:0]      lane;
    logic [31:0]     rd_word, rd_shift, load_ext, store_data, fill_word, bank_wdata;
    logic [3:0]      store_be, bank_be;
    logic [WI_W-1:0] bank_addr;
    logic            bank_we, fault;

    logic            wwreg_q, wm2reg_q, misalign_q;
    logic [4:0]      wrn_q;
    logic [31:0]     wmo_q, walu_q;

    assign wi   = addr[ADDR_W-1:2];
    assign lane = addr[1:0];

`ifdef MEM_PRELOAD_EN
    assign fill_word = 32'(cnt_q);
`else
    assign fill_word = 32'h0;
`endif

    // State and walk-counter register; reset restarts the walk from word 0
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: step through every word once, then serve requests forever
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
                state_d = ST_RUN;
            end
        end
    end

    // FSM outputs: ready flag and the single write port steering (walk vs store)
    always_comb begin
        ready      = 1'b0;
        bank_we    = 1'b0;
        bank_be    = store_be;
        bank_addr  = wi;
        bank_wdata = store_data;
        if (state_q == ST_INIT) begin
            bank_we    = clrn;
            bank_be    = 4'hF;
            bank_addr  = cnt_q;
            bank_wdata = fill_word;
        end else begin
            ready   = 1'b1;
            bank_we = clrn & en & we & ~fault;
        end
    end

    // Lane steering for stores, lane select + extension for loads, fault check
    always_comb begin
        fault      = 1'b0;
        store_be   = 4'h0;
        store_data = datain;
        rd_shift   = rd_word >> {lane, 3'b000};
        load_ext   = rd_word;
        case (size)
            SZ_BYTE: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{datain[7:0]}};
                load_ext   = uns ? {24'h0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_HALF: begin
                fault      = addr[0];
                store_be   = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{datain[15:0]}};
                load_ext   = uns ? {16'h0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            SZ_WORD: begin
                fault    = (lane != 2'b00);
                store_be = 4'hF;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    dmem_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .we_i    (bank_we),
        .be_i    (bank_be),
        .addr_i  (bank_addr),
        .wdata_i (bank_wdata),
        .rdata_o (rd_word)
    );

    // MEM/WB register: bubble unless a valid instruction is in MEM during RUN
    always_ff @(posedge clk) begin
        if (!clrn || state_q != ST_RUN || !en) begin
            wwreg_q    <= 1'b0;
            wm2reg_q   <= 1'b0;
            wrn_q      <= 5'd0;
            wmo_q      <= 32'h0;
            walu_q     <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            wwreg_q    <= mwreg & ~fault;
            wm2reg_q   <= mm2reg;
            wrn_q      <= mrn;
            wmo_q      <= fault ? 32'h0 : load_ext;
            walu_q     <= 32'(addr);
            misalign_q <= fault;
        end
    end

    assign wwreg    = wwreg_q;
    assign wm2reg   = wm2reg_q;
    assign wrn      = wrn_q;
    assign wmo      = wmo_q;
    assign walu     = walu_q;
    assign misalign = misalign_q;

endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
Parametrised data-memory stage for the pipelined CPU. It replaces the fixed 32x32 word-only memory with a configurable-depth, byte-addressed, little-endian memory. It supports byte, halfword and word loads/stores, with sign/zero extension and misalignment detection. It contains the MEM/WB pipeline register. After reset it runs a self-clear walk over the array and holds ready low until the walk completes.

Parameters:
DEPTH, 32, number of 32-bit words; power of two, minimum 4
ADDR_W, clog2(DEPTH)+2, byte-address width; derived localparam, not overridable

Ports:
clk  in  1  clock, rising edge
clrn  in  1  synchronous active-low reset
ready  out  1  1 = memory accepts requests; 0 during the clear walk
en  in  1  valid instruction in MEM this cycle
we  in  1  store request (qualified by en)
size  in  2  00 byte, 01 half, 10 word, 11 illegal
uns  in  1  1 = zero-extend loads, 0 = sign-extend loads
addr  in  ADDR_W  byte address (ALU result)
datain  in  32  store data, right-aligned
mwreg  in  1  register-write flag from EX/MEM
mm2reg  in  1  mem-to-reg flag from EX/MEM
mrn  in  5  destination register from EX/MEM
wwreg  out  1  registered write flag to WB
wm2reg  out  1  registered mem-to-reg flag to WB
wrn  out  5  registered destination register to WB
wmo  out  32  registered, extended load data
walu  out  32  registered copy of addr, zero-extended to 32 bits
misalign  out  1  registered fault flag for the instruction now in WB

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (clrn sampled at the rising edge).
- FSM states: INIT and RUN.
  - clrn low: state goes to INIT, the walk counter goes to 0, and all outputs go to 0 (ready=0, wwreg=0, wm2reg=0, wrn=0, wmo=0, walu=0, misalign=0).
- INIT state:
  - Each cycle writes the fill value to word[cnt], then cnt increments.
  - After word DEPTH-1 is written, state goes to RUN; ready=1 from the next cycle.
  - Total: exactly DEPTH cycles after clrn is released.
  - en, we and all data inputs are ignored; WB outputs stay 0.
- RUN state, en=1, with wi = addr[ADDR_W-1:2] and lane = addr[1:0]:
  - The read is combinational from the array and is captured into the MEM/WB register at the same edge the store is performed.
  - Latency: 1 cycle, request at edge N, result on the outputs after edge N.
  - Read-during-write to the same word: wmo returns the old contents (read-before-write).
  - Store byte: writes datain[7:0] to lane. Store half: writes datain[15:0] to lanes {addr[1],0}. Store word: writes all 4 lanes. Other lanes are untouched.
  - Load byte/half: select the lane(s), then sign-extend (uns=0) or zero-extend (uns=1). Load word: the whole word.
  - Fault when: half with addr[0]=1, word with addr[1:0]!=0, or size=11. On a fault:
    - no array write;
    - misalign=1, wwreg=0, wmo=0;
    - wm2reg and wrn are still passed through.
  - Non-fault: wwreg=mwreg, wm2reg=mm2reg, wrn=mrn, walu=addr, misalign=0.
- RUN state, en=0: no write; WB register loads a bubble (all outputs 0).
- Reset asserted mid-operation: any store at that edge is dropped, the walk restarts from 0, and the whole array is re-cleared.
- Address wrap: addr covers exactly DEPTH words; there is no out-of-range case.

Optional Feature:
MEM_PRELOAD_EN
- Defined: the walk writes word i with the value i, matching the existing test images.
- Undefined: the walk writes 0 to every word.
- Walk timing is identical either way.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state constants ST_INIT and ST_RUN.
- One sub-module, dmem_bank: DEPTH x 32 array with 4-bit byte-enable synchronous write and asynchronous read.
- Lane select, extension, fault logic, FSM and the MEM/WB register stay in the top module.

Test Plan:
- Release clrn at cycle 0, DEPTH=32 -> ready=0 for cycles 0-31, ready=1 at cycle 32; all outputs 0 throughout; any word read afterwards returns 0 (macro off).
- Store word 0xDEADBEEF at addr 0x08, then load word at addr 0x08 -> wmo=0xDEADBEEF one cycle after the load; wwreg=mwreg, wrn=mrn.
- Store byte 0x80 at addr 0x0D, then load byte signed at 0x0D -> wmo=0xFFFFFF80; load unsigned -> 0x00000080; load word at 0x0C -> 0x00008000.
- Store half at addr 0x03 -> misalign=1, wwreg=0, memory unchanged; size=11 -> same fault response.
- Store 0x11111111 to addr 0x10 then, with the array holding that value, issue store 0x22222222 and load at 0x10 in the same cycle -> wmo=0x11111111; the next load at 0x10 returns 0x22222222.
- Assert clrn for 1 cycle while a store is presented -> the store is dropped, ready falls, the walk re-runs for DEPTH cycles. With MEM_PRELOAD_EN: word 5 reads 0x00000005.
